// File: rtl/cve2_pkg.sv
// Shared types for the simulation/FPGA memory responder.
package cve2_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_resp_t;

  localparam int unsigned MemRespMaxLatency = 8;

endpackage

// File: rtl/cve2_mem_resp_delay.sv
// Fixed-latency shift register carrying {valid, mem_resp_t} from grant to rvalid.
module cve2_mem_resp_delay
  import cve2_pkg::*;
#(
  parameter int unsigned RespLatency = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      valid_i,
  input  mem_resp_t resp_i,
  output logic      valid_o,
  output mem_resp_t resp_o
);

  if (RespLatency < 1 || RespLatency > MemRespMaxLatency) begin : gen_bad_latency
    $fatal(1, "cve2_mem_resp_delay: RespLatency must be in 1..%0d", MemRespMaxLatency);
  end

  logic [RespLatency-1:0] valid_q;
  mem_resp_t              resp_q [RespLatency];

  // Payload is zeroed when not valid so outputs read 0 between responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < RespLatency; i++) begin
        resp_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      resp_q[0]  <= valid_i ? resp_i : '0;
      for (int i = 1; i < RespLatency; i++) begin
        valid_q[i] <= valid_q[i-1];
        resp_q[i]  <= resp_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[RespLatency-1];
  assign resp_o  = resp_q[RespLatency-1];

endmodule

// File: rtl/cve2_obi_mem_responder.sv
// Memory-side responder for the req/gnt/rvalid protocol, backed by a word array,
// with fixed response latency, bounded outstanding requests and stall injection.
module cve2_obi_mem_responder
  import cve2_pkg::*;
#(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        stall_i
);

  localparam int unsigned IdxW      = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam logic [32:0] SpanBytes = 33'(MemWords) << 2;
  localparam logic [3:0]  MaxOut    = 4'(MaxOutstanding);

  if ((MemWords == 0) || ((MemWords & (MemWords - 1)) != 0)) begin : gen_bad_words
    $fatal(1, "cve2_obi_mem_responder: MemWords must be a power of two");
  end
  if ((33'(BaseAddr) % SpanBytes) != 0) begin : gen_bad_base
    $fatal(1, "cve2_obi_mem_responder: BaseAddr must be aligned to MemWords*4");
  end
  if (RespLatency < 1 || RespLatency > MemRespMaxLatency) begin : gen_bad_latency
    $fatal(1, "cve2_obi_mem_responder: RespLatency must be in 1..%0d", MemRespMaxLatency);
  end
  if (MaxOutstanding < 1 || MaxOutstanding > 8) begin : gen_bad_outstanding
    $fatal(1, "cve2_obi_mem_responder: MaxOutstanding must be in 1..8");
  end

  logic [31:0]     mem [MemWords];
  logic [31:0]     offset;
  logic            in_range;
  logic [IdxW-1:0] idx;
  logic [3:0]      cnt_q, cnt_d;
  mem_resp_t       resp_in, resp_out;
  logic            unused_offset;

  assign offset        = addr_i - BaseAddr;
  assign in_range      = (addr_i >= BaseAddr) && ({1'b0, offset} < SpanBytes);
  assign idx           = offset[IdxW+1:2];
  assign unused_offset = ^{offset[1:0], offset[31:IdxW+2]};

  // Counter is compared registered, so a slot freed by rvalid is usable next cycle.
  assign gnt_o = req_i & ~stall_i & (cnt_q < MaxOut) & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read sees the pre-edge word; a same-edge write cannot coexist with a read grant.
  always_comb begin
    resp_in       = '0;
    resp_in.err   = ~in_range;
    if (in_range && !we_i) begin
      resp_in.rdata = mem[idx];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (gnt_o && !rvalid_o) begin
      cnt_d = cnt_q + 4'd1;
    end else if (!gnt_o && rvalid_o) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  cve2_mem_resp_delay #(
    .RespLatency(RespLatency)
  ) u_delay (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid_i(gnt_o),
    .resp_i (resp_in),
    .valid_o(rvalid_o),
    .resp_o (resp_out)
  );

  assign rdata_o = resp_out.rdata;
  assign err_o   = resp_out.err;

  cnt_bound_a: assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= MaxOut);
  cnt_underflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
                                    !(rvalid_o && !gnt_o && (cnt_q == 4'd0)));

endmodule

// File: tb/tb_cve2_obi_mem_responder.sv
// Directed bench: three responder instances with different latency/base settings.
module tb_cve2_obi_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        stall;

  logic        req_a, gnt_a, rvalid_a, err_a;
  logic [31:0] rdata_a;
  logic        req_b, gnt_b, rvalid_b, err_b;
  logic [31:0] rdata_b;
  logic        req_c, gnt_c, rvalid_c, err_c;
  logic [31:0] rdata_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cve2_obi_mem_responder #(
    .MemWords(1024), .BaseAddr(32'h0000_0000), .RespLatency(1), .MaxOutstanding(2)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .gnt_o(gnt_a), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a),
    .stall_i(stall)
  );

  cve2_obi_mem_responder #(
    .MemWords(1024), .BaseAddr(32'h0000_0000), .RespLatency(4), .MaxOutstanding(2)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .gnt_o(gnt_b), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b),
    .stall_i(stall)
  );

  cve2_obi_mem_responder #(
    .MemWords(1024), .BaseAddr(32'h0000_2000), .RespLatency(3), .MaxOutstanding(2)
  ) dut_c (
    .clk_i(clk), .rst_i(rst), .req_i(req_c), .gnt_o(gnt_c), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_c), .rdata_o(rdata_c), .err_o(err_c),
    .stall_i(stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d);
    addr  = a;
    we    = w;
    be    = b;
    wdata = d;
  endtask

  task automatic test_reset();
    req_a = 1'b1;
    drive(32'h0, 1'b0, 4'hF, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (gnt_a !== 1'b0) begin
        failures++;
        $display("FAIL reset_gnt_gated: got %b want 0", gnt_a);
      end
      tick();
    end
    req_a = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    checks++;
    if ({rvalid_a, rvalid_b, rvalid_c, gnt_a, gnt_b, gnt_c} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {rvalid_a, rvalid_b, rvalid_c, gnt_a, gnt_b, gnt_c});
    end
    checks++;
    if ({rdata_a, rdata_b, rdata_c, err_a, err_b, err_c} !== 99'b0) begin
      failures++;
      $display("FAIL reset_data: got %h %h %h err %b%b%b want zeros",
               rdata_a, rdata_b, rdata_c, err_a, err_b, err_c);
    end
    tick();
  endtask

  task automatic test_single_read();
    req_a = 1'b1;
    drive(32'h40, 1'b1, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++;
    if (gnt_a !== 1'b1) begin
      failures++;
      $display("FAIL sr_wr_gnt: got %b want 1", gnt_a);
    end
    tick();
    req_a = 1'b0;
    drive(32'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({rvalid_a, err_a, rdata_a} !== {1'b1, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL sr_wr_resp: got v=%b e=%b d=%h want v=1 e=0 d=00000000",
               rvalid_a, err_a, rdata_a);
    end
    tick();
    req_a = 1'b1;
    drive(32'h40, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({gnt_a, rvalid_a} !== 2'b10) begin
      failures++;
      $display("FAIL sr_rd_gnt: got gnt=%b rvalid=%b want gnt=1 rvalid=0", gnt_a, rvalid_a);
    end
    tick();
    req_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({rvalid_a, err_a, rdata_a} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL sr_rd_resp: got v=%b e=%b d=%h want v=1 e=0 d=deadbeef",
               rvalid_a, err_a, rdata_a);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({rvalid_a, rdata_a} !== 33'h0) begin
      failures++;
      $display("FAIL sr_idle: got v=%b d=%h want v=0 d=00000000", rvalid_a, rdata_a);
    end
    tick();
  endtask

  task automatic test_byte_enable();
    req_a = 1'b1;
    drive(32'h80, 1'b1, 4'hF, 32'h0);
    @(negedge clk);
    checks++;
    if (gnt_a !== 1'b1) begin
      failures++;
      $display("FAIL be_clear_gnt: got %b want 1", gnt_a);
    end
    tick();
    drive(32'h80, 1'b1, 4'b0101, 32'h1122_3344);
    @(negedge clk);
    checks++;
    if ({gnt_a, rvalid_a} !== 2'b11) begin
      failures++;
      $display("FAIL be_write_b2b: got gnt=%b rvalid=%b want 11", gnt_a, rvalid_a);
    end
    tick();
    drive(32'h80, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({gnt_a, rvalid_a, rdata_a} !== {2'b11, 32'h0}) begin
      failures++;
      $display("FAIL be_read_b2b: got gnt=%b rvalid=%b d=%h want 11 d=00000000",
               gnt_a, rvalid_a, rdata_a);
    end
    tick();
    req_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({rvalid_a, err_a, rdata_a} !== {1'b1, 1'b0, 32'h0022_0044}) begin
      failures++;
      $display("FAIL be_merge: got v=%b e=%b d=%h want v=1 e=0 d=00220044",
               rvalid_a, err_a, rdata_a);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    req_a = 1'b1;
    drive(32'h0, 1'b1, 4'hF, 32'hA5A5_A5A5);
    tick();
    drive(32'h1000, 1'b1, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    checks++;
    if ({gnt_a, rvalid_a, err_a} !== 3'b110) begin
      failures++;
      $display("FAIL oor_wr_gnt: got gnt=%b v=%b e=%b want 110", gnt_a, rvalid_a, err_a);
    end
    tick();
    drive(32'h1000, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({rvalid_a, err_a, rdata_a} !== {2'b11, 32'h0}) begin
      failures++;
      $display("FAIL oor_wr_resp: got v=%b e=%b d=%h want v=1 e=1 d=00000000",
               rvalid_a, err_a, rdata_a);
    end
    tick();
    drive(32'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({rvalid_a, err_a, rdata_a} !== {2'b11, 32'h0}) begin
      failures++;
      $display("FAIL oor_rd_resp: got v=%b e=%b d=%h want v=1 e=1 d=00000000",
               rvalid_a, err_a, rdata_a);
    end
    tick();
    req_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({rvalid_a, err_a, rdata_a} !== {2'b10, 32'hA5A5_A5A5}) begin
      failures++;
      $display("FAIL oor_no_alias: got v=%b e=%b d=%h want v=1 e=0 d=a5a5a5a5",
               rvalid_a, err_a, rdata_a);
    end
    tick();
  endtask

  task automatic test_outstanding();
    logic [9:0] exp_gnt;
    logic [9:0] exp_rvalid;
    exp_gnt    = 10'b00_0110_0011;
    exp_rvalid = 10'b10_0011_0000;
    req_b = 1'b1;
    drive(32'h0, 1'b0, 4'h0, 32'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({gnt_b, rvalid_b} !== {exp_gnt[c], exp_rvalid[c]}) begin
        failures++;
        $display("FAIL outstanding_c%0d: got gnt=%b rvalid=%b want gnt=%b rvalid=%b",
                 c, gnt_b, rvalid_b, exp_gnt[c], exp_rvalid[c]);
      end
      tick();
    end
    req_b = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_stall();
    req_c = 1'b1;
    drive(32'h2010, 1'b1, 4'hF, 32'hCAFE_F00D);
    tick();
    req_c = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if ({rvalid_c, err_c} !== 2'b10) begin
      failures++;
      $display("FAIL stall_prewrite: got v=%b e=%b want v=1 e=0", rvalid_c, err_c);
    end
    tick();
    stall = 1'b1;
    req_c = 1'b1;
    drive(32'h2010, 1'b0, 4'h0, 32'h0);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      checks++;
      if (gnt_c !== 1'b0) begin
        failures++;
        $display("FAIL stall_c%0d: got gnt=%b want 0", s, gnt_c);
      end
      tick();
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_c !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_gnt: got %b want 1", gnt_c);
    end
    tick();
    req_c = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      checks++;
      if (rvalid_c !== 1'b0) begin
        failures++;
        $display("FAIL stall_early_rvalid_%0d: got %b want 0", s, rvalid_c);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({rvalid_c, err_c, rdata_c} !== {2'b10, 32'hCAFE_F00D}) begin
      failures++;
      $display("FAIL stall_resp: got v=%b e=%b d=%h want v=1 e=0 d=cafef00d",
               rvalid_c, err_c, rdata_c);
    end
    tick();
  endtask

  task automatic test_below_base();
    req_c = 1'b1;
    drive(32'h1FFC, 1'b0, 4'h0, 32'h0);
    tick();
    req_c = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if ({rvalid_c, err_c, rdata_c} !== {2'b11, 32'h0}) begin
      failures++;
      $display("FAIL below_base: got v=%b e=%b d=%h want v=1 e=1 d=00000000",
               rvalid_c, err_c, rdata_c);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    logic [2:0] exp_gnt;
    exp_gnt = 3'b011;
    req_c = 1'b1;
    drive(32'h2010, 1'b0, 4'h0, 32'h0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_c !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_gnt: got %b want 0", gnt_c);
    end
    tick();
    rst   = 1'b0;
    req_c = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rvalid_c !== 1'b0) begin
        failures++;
        $display("FAIL mid_rst_ghost_%0d: got rvalid=%b want 0", i, rvalid_c);
      end
      tick();
    end
    req_c = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      checks++;
      if (gnt_c !== exp_gnt[e]) begin
        failures++;
        $display("FAIL mid_rst_regrant_%0d: got gnt=%b want %b", e, gnt_c, exp_gnt[e]);
      end
      tick();
    end
    req_c = 1'b0;
    @(negedge clk);
    checks++;
    if ({rvalid_c, err_c, rdata_c} !== {2'b10, 32'hCAFE_F00D}) begin
      failures++;
      $display("FAIL mid_rst_resp: got v=%b e=%b d=%h want v=1 e=0 d=cafef00d",
               rvalid_c, err_c, rdata_c);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rvalid_c !== 1'b1) begin
      failures++;
      $display("FAIL mid_rst_resp2: got rvalid=%b want 1", rvalid_c);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({rvalid_c, rdata_c} !== 33'h0) begin
      failures++;
      $display("FAIL mid_rst_drain: got v=%b d=%h want v=0 d=00000000", rvalid_c, rdata_c);
    end
    tick();
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    req_c = 1'b0;
    drive(32'h0, 1'b0, 4'h0, 32'h0);
    tick();
    test_reset();
    test_single_read();
    test_byte_enable();
    test_out_of_range();
    test_outstanding();
    test_stall();
    test_below_base();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
